// File: rtl/instr_seq_pkg.sv
// Shared definitions for the instruction sequencer.
//   - state_t     : sequencer FSM state encoding
//   - BS_*        : decoder branch-select codes
//   - MD_LOAD     : decoder data-select code for a load
//   - NOP_OPCODE  : opcode field of the all-zero instruction
//   - is_mem_op() : true when the decoded instruction needs data memory
package instr_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_BRANCH = 3'd5,
        ST_FAULT  = 3'd6
    } state_t;

    localparam logic [1:0] BS_NONE = 2'b00;
    localparam logic [1:0] BS_COND = 2'b01;
    localparam logic [1:0] BS_JMR  = 2'b10;
    localparam logic [1:0] BS_JMP  = 2'b11;

    localparam logic [1:0] MD_LOAD = 2'b01;

    localparam logic [6:0] NOP_OPCODE = 7'b0000000;

    // Stores and loads both go through MEM; a store is flagged by MW,
    // a load by the data-select picking memory data for writeback.
    function automatic logic is_mem_op(input logic mw, input logic [1:0] md);
        return mw || (md == MD_LOAD);
    endfunction

endpackage

// File: rtl/instr_sequencer_ack_watchdog.sv
// Wait-cycle watchdog shared by the FETCH and MEM handshakes.
//   clk, rst_n : clock and asynchronous active-low reset
//   en         : a request is outstanding (counting allowed)
//   ack        : the memory answered this cycle
//   expire     : this is the TIMEOUT-th wait cycle and no ack arrived
// The count clears whenever en drops (state exit) or ack arrives, so an
// ack in the final allowed cycle always wins over expiry.
module ack_watchdog #(
    parameter int TIMEOUT = 15,
    parameter int TO_W    = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic ack,
    output logic expire
);

    logic [TO_W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (!en || ack) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + TO_W'(1);
        end
    end

    // Count holds the number of wait cycles already spent, so the
    // current cycle is number count_reg+1.
    assign expire = en && !ack && (count_reg == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle control FSM for the RISC core.
//   CLK, RESET           : clock, asynchronous active-low reset
//   ENABLE               : run permission, sampled in IDLE and at retirement
//   IMEM_REQ/ACK/DATA    : instruction fetch handshake
//   IR_instruction       : instruction register feeding the decoder
//   RW, MW, MD, BS       : decoder control fields for the current IR
//   BRANCH_COND          : branch condition, valid in BRANCH
//   DMEM_REQ/WE/ACK      : data memory handshake
//   RW_EN, PC_INC, PC_LOAD : single-cycle strobes per instruction
//   BUSY, FAULT          : status; FAULT is sticky until reset
//   RETIRED              : wrapping retired-instruction count
module instr_sequencer
    import instr_seq_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15,
    parameter int TO_W    = 4,
    parameter int CNT_W   = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ENABLE,
    output logic              IMEM_REQ,
    input  logic              IMEM_ACK,
    input  logic [DATA_W-1:0] IMEM_DATA,
    output logic [DATA_W-1:0] IR_instruction,
    input  logic              RW,
    input  logic              MW,
    input  logic [1:0]        MD,
    input  logic [1:0]        BS,
    input  logic              BRANCH_COND,
    output logic              DMEM_REQ,
    output logic              DMEM_WE,
    input  logic              DMEM_ACK,
    output logic              RW_EN,
    output logic              PC_INC,
    output logic              PC_LOAD,
    output logic              BUSY,
    output logic              FAULT,
    output logic [CNT_W-1:0]  RETIRED
);

    state_t            state_reg, state_next;
    logic [DATA_W-1:0] ir_reg;
    logic [CNT_W-1:0]  retired_reg;
    logic              wd_en, wd_ack, wd_expire;
    logic              retire;

    ack_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_watchdog (
        .clk    (CLK),
        .rst_n  (RESET),
        .en     (wd_en),
        .ack    (wd_ack),
        .expire (wd_expire)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_reg   <= ST_IDLE;
            ir_reg      <= '0;
            retired_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_FETCH && IMEM_ACK) begin
                ir_reg <= IMEM_DATA;
            end
            if (retire) begin
                retired_reg <= retired_reg + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        IMEM_REQ   = 1'b0;
        DMEM_REQ   = 1'b0;
        DMEM_WE    = 1'b0;
        RW_EN      = 1'b0;
        PC_INC     = 1'b0;
        PC_LOAD    = 1'b0;
        wd_en      = 1'b0;
        wd_ack     = 1'b0;
        retire     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (ENABLE) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                IMEM_REQ = 1'b1;
                wd_en    = 1'b1;
                wd_ack   = IMEM_ACK;
                if (IMEM_ACK)       state_next = ST_DECODE;
                else if (wd_expire) state_next = ST_FAULT;
            end
            ST_DECODE: begin
                if (is_mem_op(MW, MD))  state_next = ST_MEM;
                else if (BS != BS_NONE) state_next = ST_BRANCH;
                else                    state_next = ST_EXEC;
            end
            ST_EXEC: begin
                RW_EN  = RW;
                PC_INC = 1'b1;
                retire = 1'b1;
            end
            ST_MEM: begin
                DMEM_REQ = 1'b1;
                DMEM_WE  = MW;
                wd_en    = 1'b1;
                wd_ack   = DMEM_ACK;
                if (DMEM_ACK) begin
                    // Load writeback and PC advance only on completion.
                    RW_EN  = RW;
                    PC_INC = 1'b1;
                    retire = 1'b1;
                end else if (wd_expire) begin
                    state_next = ST_FAULT;
                end
            end
            ST_BRANCH: begin
                // Only a not-taken conditional branch falls through;
                // JMR/JMP/JML and taken conditionals load the target.
                if (BS == BS_COND && !BRANCH_COND) PC_INC  = 1'b1;
                else                               PC_LOAD = 1'b1;
                RW_EN  = RW;
                retire = 1'b1;
            end
            ST_FAULT: begin
                state_next = ST_FAULT;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (retire) state_next = ENABLE ? ST_FETCH : ST_IDLE;
    end

    assign IR_instruction = ir_reg;
    assign RETIRED        = retired_reg;
    assign BUSY           = (state_reg != ST_IDLE) && (state_reg != ST_FAULT);
    assign FAULT          = (state_reg == ST_FAULT);

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        ENABLE;
    logic        IMEM_REQ;
    logic        IMEM_ACK;
    logic [31:0] IMEM_DATA;
    logic [31:0] IR_instruction;
    logic        RW, MW;
    logic [1:0]  MD, BS;
    logic        BRANCH_COND;
    logic        DMEM_REQ, DMEM_WE, DMEM_ACK;
    logic        RW_EN, PC_INC, PC_LOAD;
    logic        BUSY, FAULT;
    logic [15:0] RETIRED;

    instr_sequencer dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .ENABLE         (ENABLE),
        .IMEM_REQ       (IMEM_REQ),
        .IMEM_ACK       (IMEM_ACK),
        .IMEM_DATA      (IMEM_DATA),
        .IR_instruction (IR_instruction),
        .RW             (RW),
        .MW             (MW),
        .MD             (MD),
        .BS             (BS),
        .BRANCH_COND    (BRANCH_COND),
        .DMEM_REQ       (DMEM_REQ),
        .DMEM_WE        (DMEM_WE),
        .DMEM_ACK       (DMEM_ACK),
        .RW_EN          (RW_EN),
        .PC_INC         (PC_INC),
        .PC_LOAD        (PC_LOAD),
        .BUSY           (BUSY),
        .FAULT          (FAULT),
        .RETIRED        (RETIRED)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] instr;
        int          idly;     // FETCH wait cycles before ack (99 = never)
        logic        rw;
        logic        mw;
        logic [1:0]  md;
        logic [1:0]  bs;
        logic        cond;
        int          dly;      // MEM wait cycles before ack
        int          e_cyc;    // busy cycles
        int          e_rw;
        int          e_inc;
        int          e_load;
        int          e_dreq;
        int          e_we;
        int          e_ireq;
        logic        e_fault;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs [NVEC];

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_ir;
    logic [15:0] exp_ret;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One instruction from IDLE back to IDLE/FAULT. ENABLE is dropped after
    // the first cycle, so completion also exercises the no-abort rule.
    task automatic run_vec(input vec_t v, output int cyc, output int n_rw,
                           output int n_inc, output int n_load, output int n_dreq,
                           output int n_we, output int n_ireq, output int n_early);
        int iwait, dwait;
        cyc = 0; n_rw = 0; n_inc = 0; n_load = 0; n_dreq = 0;
        n_we = 0; n_ireq = 0; n_early = 0; iwait = 0; dwait = 0;
        IMEM_DATA = v.instr; RW = v.rw; MW = v.mw; MD = v.md; BS = v.bs;
        BRANCH_COND = v.cond;
        ENABLE = 1'b1;
        @(posedge CLK); #1;
        ENABLE = 1'b0;
        while (BUSY && cyc < 40) begin
            IMEM_ACK = IMEM_REQ && (iwait == v.idly);
            DMEM_ACK = DMEM_REQ && (dwait == v.dly);
            if (IMEM_REQ) iwait++;
            if (DMEM_REQ) dwait++;
            #1;
            cyc++;
            n_rw   += int'(RW_EN);
            n_inc  += int'(PC_INC);
            n_load += int'(PC_LOAD);
            n_dreq += int'(DMEM_REQ);
            n_we   += int'(DMEM_WE);
            n_ireq += int'(IMEM_REQ);
            if (DMEM_REQ && !DMEM_ACK && (RW_EN || PC_INC || PC_LOAD)) n_early++;
            @(posedge CLK); #1;
        end
        IMEM_ACK = 1'b0;
        DMEM_ACK = 1'b0;
    endtask

    initial begin
        int cyc, n_rw, n_inc, n_load, n_dreq, n_we, n_ireq, n_early;
        int bad_win;

        //           instr         idly rw    mw    md     bs     cond  dly cyc rw inc ld dreq we ireq fault
        vecs[0]  = '{32'h0412_3000, 0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 0,  3, 1, 1, 0, 0, 0, 1, 1'b0}; // ADD
        vecs[1]  = '{32'h2012_0000, 0, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 4,  7, 1, 1, 0, 5, 0, 1, 1'b0}; // LD, 4 waits
        vecs[2]  = '{32'h4001_8000, 0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 2,  5, 0, 1, 0, 3, 3, 1, 1'b0}; // ST, 2 waits
        vecs[3]  = '{32'hC100_0005, 0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 0,  3, 0, 1, 0, 0, 0, 1, 1'b0}; // BZ not taken
        vecs[4]  = '{32'hC300_0007, 0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b1, 0,  3, 0, 0, 1, 0, 0, 1, 1'b0}; // BNZ taken
        vecs[5]  = '{32'hE000_0040, 0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 0,  3, 0, 0, 1, 0, 0, 1, 1'b0}; // JMR
        vecs[6]  = '{32'hE480_0020, 0, 1'b1, 1'b0, 2'b00, 2'b11, 1'b0, 0,  3, 1, 0, 1, 0, 0, 1, 1'b0}; // JML
        vecs[7]  = '{32'h0000_0000, 0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 0,  3, 0, 1, 0, 0, 0, 1, 1'b0}; // NOP
        vecs[8]  = '{32'h4101_0000, 0, 1'b0, 1'b1, 2'b00, 2'b01, 1'b1, 0,  3, 0, 1, 0, 1, 1, 1, 1'b0}; // MW beats BS
        vecs[9]  = '{32'h0A23_1000, 14, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 0, 17, 1, 1, 0, 0, 0, 15, 1'b0}; // ack on wait 15
        vecs[10] = '{32'h0B00_0000, 99, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 0, 15, 0, 0, 0, 0, 0, 15, 1'b1}; // no ack

        RESET = 1'b0; ENABLE = 1'b0; IMEM_ACK = 1'b0; DMEM_ACK = 1'b0;
        IMEM_DATA = 32'hFFFF_FFFF; RW = 1'b0; MW = 1'b0; MD = 2'b00; BS = 2'b00;
        BRANCH_COND = 1'b0;
        #12;
        chk("reset_ir", IR_instruction, 32'h0);
        chk("reset_retired", {16'h0, RETIRED}, 32'h0);
        chk("reset_status", {28'h0, BUSY, FAULT, IMEM_REQ, DMEM_REQ}, 32'h0);
        chk("reset_strobes", {29'h0, RW_EN, PC_INC, PC_LOAD}, 32'h0);
        #10 RESET = 1'b1;
        @(posedge CLK); #1;
        chk("idle_busy", {31'h0, BUSY}, 32'h0);

        exp_ir = 32'h0;
        exp_ret = 16'h0;
        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i], cyc, n_rw, n_inc, n_load, n_dreq, n_we, n_ireq, n_early);
            if (!vecs[i].e_fault) begin
                exp_ir = vecs[i].instr;
                exp_ret = exp_ret + 16'd1;
            end
            $display("vec %0d instr %h cyc %0d rw_en %0d pc_inc %0d pc_load %0d dreq %0d we %0d ireq %0d retired %0d fault %0b",
                     i, vecs[i].instr, cyc, n_rw, n_inc, n_load, n_dreq, n_we, n_ireq, RETIRED, FAULT);
            chk($sformatf("v%0d_cycles", i),  cyc,     vecs[i].e_cyc);
            chk($sformatf("v%0d_rw_en", i),   n_rw,    vecs[i].e_rw);
            chk($sformatf("v%0d_pc_inc", i),  n_inc,   vecs[i].e_inc);
            chk($sformatf("v%0d_pc_load", i), n_load,  vecs[i].e_load);
            chk($sformatf("v%0d_dmem_req", i), n_dreq, vecs[i].e_dreq);
            chk($sformatf("v%0d_dmem_we", i), n_we,    vecs[i].e_we);
            chk($sformatf("v%0d_imem_req", i), n_ireq, vecs[i].e_ireq);
            chk($sformatf("v%0d_early_strobe", i), n_early, 0);
            chk($sformatf("v%0d_ir", i), IR_instruction, exp_ir);
            chk($sformatf("v%0d_retired", i), {16'h0, RETIRED}, {16'h0, exp_ret});
            chk($sformatf("v%0d_fault", i), {31'h0, FAULT}, {31'h0, vecs[i].e_fault});
            chk($sformatf("v%0d_end_imem_req", i), {31'h0, IMEM_REQ}, 32'h0);
        end

        // FAULT is sticky: ENABLE and both acks must not wake it up.
        ENABLE = 1'b1; IMEM_ACK = 1'b1; DMEM_ACK = 1'b1;
        bad_win = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge CLK); #1;
            if (!FAULT || BUSY || IMEM_REQ || DMEM_REQ || RW_EN || PC_INC || PC_LOAD) bad_win++;
        end
        $display("fault hold window: bad cycles %0d", bad_win);
        chk("fault_sticky", bad_win, 0);
        ENABLE = 1'b0; IMEM_ACK = 1'b0; DMEM_ACK = 1'b0;

        // Reset clears FAULT, then a load is interrupted by reset in MEM.
        #3 RESET = 1'b0;
        #1 chk("fault_cleared", {31'h0, FAULT}, 32'h0);
        #10 RESET = 1'b1;
        exp_ret = 16'h0;
        @(posedge CLK); #1;
        IMEM_DATA = 32'h2055_0000; RW = 1'b1; MW = 1'b0; MD = 2'b01; BS = 2'b00;
        ENABLE = 1'b1;
        @(posedge CLK); #1;             // FETCH
        ENABLE = 1'b0; IMEM_ACK = 1'b1;
        @(posedge CLK); #1;             // DECODE
        IMEM_ACK = 1'b0;
        @(posedge CLK); #1;             // MEM, first wait
        @(posedge CLK); #1;             // MEM, second wait
        chk("pre_reset_dmem_req", {31'h0, DMEM_REQ}, 32'h1);
        chk("pre_reset_ir", IR_instruction, 32'h2055_0000);
        #2 RESET = 1'b0;
        #1;
        $display("reset mid-MEM: dmem_req %0b ir %h retired %0d busy %0b", DMEM_REQ, IR_instruction, RETIRED, BUSY);
        chk("midmem_dmem_req", {31'h0, DMEM_REQ}, 32'h0);
        chk("midmem_ir", IR_instruction, 32'h0);
        chk("midmem_retired", {16'h0, RETIRED}, 32'h0);
        chk("midmem_strobes", {29'h0, RW_EN, PC_INC, PC_LOAD}, 32'h0);
        DMEM_ACK = 1'b1;
        @(posedge CLK); #1;
        chk("midmem_hold_strobes", {28'h0, RW_EN, PC_INC, PC_LOAD, BUSY}, 32'h0);
        DMEM_ACK = 1'b0;
        RESET = 1'b1;
        @(posedge CLK); #1;
        chk("post_reset_busy", {31'h0, BUSY}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
